// File: rtl/branch_predict_resolve.sv
// Branch prediction and resolution for the EX stage.
// A direct-mapped BTB with 2-bit saturating counters supplies the IF-stage
// next-PC prediction. EX resolves conditional branches and jumps, compares
// the real outcome with the prediction carried down the pipe, and requests
// a flush/redirect only when the two disagree. Two saturating statistics
// counters track resolved control-flow instructions and mispredicts.
//
// Qualifier rule: EX_VALID marks a real instruction in EX. When it is low,
// nothing in EX can flush, train the BTB or bump a counter, whatever the
// other EX inputs show. There is no ready/backpressure path.

module branch_predict_resolve #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  // fetch-side lookup
  input  logic [31:0]      IF_PC,
  output logic             PRED_TAKEN,
  output logic [31:0]      PRED_TARGET,
  // execute-side resolution
  input  logic             EX_VALID,
  input  logic             BRANCH,
  input  logic             JUMP,
  input  logic             JALR,
  input  logic             ZERO,
  input  logic [31:0]      ALU_OUT,
  input  logic [2:0]       Func3,
  input  logic [31:0]      PC,
  input  logic [31:0]      IMM_VALUE,
  input  logic             EX_PRED_TAKEN,
  input  logic [31:0]      EX_PRED_TARGET,
  output logic [31:0]      NEXT_PC,
  output logic             MUX_SELECT,
  output logic             FLUSH,
  // statistics
  output logic [CNT_W-1:0] BRANCH_COUNT,
  output logic [CNT_W-1:0] MISPREDICT_COUNT
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // ---------------------------------------------------------------------
  // BTB storage
  // ---------------------------------------------------------------------
  logic             valid_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q     [ENTRIES];
  logic [31:0]      target_q  [ENTRIES];
  logic [1:0]       ctr_q     [ENTRIES];
  logic             is_jump_q [ENTRIES];

  // ---------------------------------------------------------------------
  // IF lookup (purely from registered state, no bypass of EX updates)
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             if_pc_unused;

  assign if_idx = IF_PC[IDX_W+1:2];
  assign if_tag = IF_PC[31:IDX_W+2];
  // Instructions are word aligned; the byte offset takes no part in lookup.
  assign if_pc_unused = ^IF_PC[1:0];

  // Predict taken on a hit that is either a jump or a strongly/weakly taken branch
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    PRED_TAKEN  = if_hit && (is_jump_q[if_idx] || ctr_q[if_idx][1]);
    PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : 32'd0;
  end

  // ---------------------------------------------------------------------
  // EX resolution
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             is_cf;
  logic             cond;
  logic             actual_taken;
  logic [31:0]      pc_plus4;
  logic [31:0]      res_target;
  logic             mis_dir;
  logic             mis_tgt;
  logic             alias_hit;

  assign ex_idx = PC[IDX_W+1:2];
  assign ex_tag = PC[31:IDX_W+2];

  // Evaluate the branch condition from the ALU flags and selected compare
  always_comb begin
    cond = 1'b0;
    case (Func3)
      3'b000:         cond = ZERO;
      3'b001:         cond = ~ZERO;
      3'b100, 3'b110: cond = ALU_OUT[0];
      3'b101, 3'b111: cond = ~ALU_OUT[0];
      default:        cond = 1'b0;
    endcase
  end

  // Resolve direction, target and whether the prediction was wrong
  always_comb begin
    is_cf        = BRANCH | JUMP;
    // A jump is always taken, so JUMP dominates when BRANCH is also set.
    actual_taken = JUMP | (BRANCH & cond);
    pc_plus4     = PC + 32'd4;
    res_target   = JALR ? {ALU_OUT[31:1], 1'b0} : (PC + IMM_VALUE);
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    mis_dir   = is_cf & (actual_taken != EX_PRED_TAKEN);
    mis_tgt   = is_cf & actual_taken & EX_PRED_TAKEN & (res_target != EX_PRED_TARGET);
    // A non-control instruction predicted taken: the BTB entry aliased it.
    alias_hit = ~is_cf & EX_PRED_TAKEN;

    FLUSH      = EX_VALID & (mis_dir | mis_tgt | alias_hit);
    MUX_SELECT = FLUSH;
    NEXT_PC    = actual_taken ? res_target : pc_plus4;
  end

  // ---------------------------------------------------------------------
  // BTB training
  // ---------------------------------------------------------------------
  logic       upd_en;
  logic       inv_en;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_inc;
  logic [1:0] ctr_dec;

  // Saturating counter neighbours of the entry being resolved
  always_comb begin
    upd_en  = EX_VALID & is_cf;
    inv_en  = EX_VALID & alias_hit & ex_hit;
    ctr_cur = ctr_q[ex_idx];
    ctr_inc = (ctr_cur == 2'b11) ? 2'b11 : (ctr_cur + 2'd1);
    ctr_dec = (ctr_cur == 2'b00) ? 2'b00 : (ctr_cur - 2'd1);
  end

  // Allocate or train the indexed entry; drop entries that aliased; reset wins
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]   <= 1'b0;
        tag_q[i]     <= '0;
        target_q[i]  <= 32'd0;
        ctr_q[i]     <= 2'b01;
        is_jump_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      valid_q[ex_idx]   <= 1'b1;
      tag_q[ex_idx]     <= ex_tag;
      is_jump_q[ex_idx] <= JUMP;
      if (!ex_hit) begin
        target_q[ex_idx] <= actual_taken ? res_target : pc_plus4;
        ctr_q[ex_idx]    <= actual_taken ? 2'b10 : 2'b01;
      end else if (actual_taken) begin
        target_q[ex_idx] <= res_target;
        ctr_q[ex_idx]    <= ctr_inc;
      end else begin
        ctr_q[ex_idx]    <= ctr_dec;
      end
    end else if (inv_en) begin
      valid_q[ex_idx] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count resolved control flow and flushes, holding at all-ones
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      BRANCH_COUNT     <= '0;
      MISPREDICT_COUNT <= '0;
    end else begin
      if (upd_en && (BRANCH_COUNT != CNT_MAX))
        BRANCH_COUNT <= BRANCH_COUNT + 1'b1;
      if (FLUSH && (MISPREDICT_COUNT != CNT_MAX))
        MISPREDICT_COUNT <= MISPREDICT_COUNT + 1'b1;
    end
  end

endmodule
